// File: rtl/aichip_pkg.sv
// Shared constants, state encoding and helper for the AI-chip weight path.
package aichip_pkg;

    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_KH   = 3;
    localparam int unsigned DEF_KW   = 3;
    localparam int unsigned DEF_CIN  = 3;
    localparam int unsigned DEF_COUT = 2;

    // Shadow-bank fill state: LOAD accepts words, FULL waits for a swap
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } wbuf_state_e;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wbuf_bank.sv
// One weight bank: NUM x DW register array, single write port, flattened read bus.
module wbuf_bank
    import aichip_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned NUM = DEF_KH * DEF_KW * DEF_CIN * DEF_COUT,
    parameter int unsigned AW  = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     data_i,
    output logic [NUM*DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [NUM];

    // Storage write; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    // Flatten array onto read bus, word k at slice k
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < int'(NUM); k++) begin
            rdata_o[k*DW +: DW] = mem_q[k];
        end
    end

endmodule

// File: rtl/weight_pingpong_buf.sv
// Double-buffered conv weight store: shadow bank fills while active bank drives dout.
// Optional feature macro: WBUF_CHECKSUM_EN (running checksum of the active set).
module weight_pingpong_buf
    import aichip_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned KH   = DEF_KH,
    parameter int unsigned KW   = DEF_KW,
    parameter int unsigned CIN  = DEF_CIN,
    parameter int unsigned COUT = DEF_COUT
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [DW-1:0]                               s_data,
    input  logic                                        swap,
    output logic                                        swap_err,
    output logic                                        loaded,
    output logic                                        active_valid,
    output logic                                        bank_sel,
    output logic [KH*KW*CIN*COUT*DW-1:0]                dout,
    output logic [DW+$clog2(KH*KW*CIN*COUT)-1:0]        checksum
);

    localparam int unsigned NUM    = KH * KW * CIN * COUT;
    localparam int unsigned CW     = DW + $clog2(NUM);
    localparam int unsigned AW_RAW = clog2(NUM);
    localparam int unsigned AW     = (AW_RAW < 1) ? 1 : AW_RAW;

    wbuf_state_e       state_q, state_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic              bank_sel_q, bank_sel_d;
    logic              active_valid_q, active_valid_d;
    logic              swap_err_q, swap_err_d;
    logic              wr_en_c;
    logic [NUM*DW-1:0] rd0_c, rd1_c;

    // Shadow bank is the one not selected; only it ever receives writes
    wbuf_bank #(.DW(DW), .NUM(NUM), .AW(AW)) u_bank0 (
        .clk     (clk),
        .we_i    (wr_en_c & bank_sel_q),
        .addr_i  (wr_cnt_q),
        .data_i  (s_data),
        .rdata_o (rd0_c)
    );

    wbuf_bank #(.DW(DW), .NUM(NUM), .AW(AW)) u_bank1 (
        .clk     (clk),
        .we_i    (wr_en_c & ~bank_sel_q),
        .addr_i  (wr_cnt_q),
        .data_i  (s_data),
        .rdata_o (rd1_c)
    );

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            wr_cnt_q       <= '0;
            bank_sel_q     <= 1'b0;
            active_valid_q <= 1'b0;
            swap_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            bank_sel_q     <= bank_sel_d;
            active_valid_q <= active_valid_d;
            swap_err_q     <= swap_err_d;
        end
    end

    // Next-state: fill shadow in LOAD, wait for swap in FULL
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        bank_sel_d     = bank_sel_q;
        active_valid_d = active_valid_q;
        swap_err_d     = 1'b0;
        wr_en_c        = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    wr_en_c = 1'b1;
                    if (wr_cnt_q == AW'(NUM - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = FULL;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
                // Swap before the set is complete is rejected, fill continues
                if (swap) begin
                    swap_err_d = 1'b1;
                end
            end
            FULL: begin
                if (swap) begin
                    bank_sel_d     = ~bank_sel_q;
                    active_valid_d = 1'b1;
                    state_d        = LOAD;
                    wr_cnt_d       = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

`ifdef WBUF_CHECKSUM_EN
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] checksum_q, checksum_d;

    // Running sum of the shadow set, committed to checksum on swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    // Accumulate accepted words; clear when a swap re-enters LOAD
    always_comb begin
        acc_d      = acc_q;
        checksum_d = checksum_q;
        if (wr_en_c) begin
            acc_d = acc_q + CW'(s_data);
        end
        if ((state_q == FULL) && swap) begin
            checksum_d = acc_q;
            acc_d      = '0;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign s_ready      = (state_q == LOAD);
    assign loaded       = (state_q == FULL);
    assign swap_err     = swap_err_q;
    assign bank_sel     = bank_sel_q;
    assign active_valid = active_valid_q;
    assign dout         = active_valid_q ? (bank_sel_q ? rd1_c : rd0_c) : '0;

endmodule
